// File: rtl/react_score_keeper_pkg.sv
// rtl/react_score_keeper_pkg.sv - shared state codes, player codes and sizing for the score keeper
//
// Purpose: constants shared by the score keeper and its users.
//   machine_state_e : top FSM state encoding seen on machine_state
//   PLAYER_A/B      : cur_player encoding
//   MAX_TRIALS      : stored trials per player before further stores are dropped
//   TIME_MAX        : reaction time clamp (three BCD digits)
//   CNT_W / SUM_W   : trial counter and accumulator widths
//   TIME_W          : reaction time / average width
package react_score_keeper_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    CLR_CNT1 = 3'd2,
    START    = 3'd3,
    STORAGE  = 3'd4,
    CLR_CNT2 = 3'd5,
    AVERAGE  = 3'd6,
    COMPARE  = 3'd7
  } machine_state_e;

  localparam logic PLAYER_A = 1'b1;
  localparam logic PLAYER_B = 1'b0;

  localparam int MAX_TRIALS = 8;
  localparam int TIME_MAX   = 999;
  localparam int TIME_W     = 10;
  localparam int CNT_W      = 4;
  localparam int SUM_W      = TIME_W + CNT_W;

  // Saturate a measured time to the largest value the display can show.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t,
                                                   input logic [TIME_W-1:0] t_max);
    return (t > t_max) ? t_max : t;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per cycle
//
// Purpose: unsigned dividend / divisor, MSB first over N_W cycles.
// Ports:
//   clk, rstn  : clock, async active-low reset
//   start      : accepted only in D_IDLE; samples dividend and divisor
//   abort      : returns to D_IDLE at once, no done pulse
//   dividend   : N_W-bit numerator
//   divisor    : D_W-bit denominator; 0 skips the run and yields quotient 0
//   quotient   : low Q_W bits of the result, valid while done is high
//   busy       : high in D_RUN and D_DONE
//   done       : high for the single D_DONE cycle
module seq_divider #(
  parameter int N_W = 14,
  parameter int D_W = 4,
  parameter int Q_W = N_W
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [Q_W-1:0] quotient,
  output logic           busy,
  output logic           done
);

  localparam int C_W = $clog2(N_W);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } div_state_e;

  div_state_e     state_q;
  logic [N_W-1:0] dvd_q;
  logic [D_W-1:0] dsr_q;
  logic [D_W-1:0] rem_q;
  logic [Q_W-1:0] quo_q;
  logic [C_W-1:0] cnt_q;

  logic [D_W:0]   rem_shift;
  logic           sub_ok;
  logic [D_W-1:0] rem_d;
  logic [Q_W-1:0] quo_d;

  // Remainder stays below the divisor, so the shifted-in value needs one
  // extra bit only for the compare; the difference always fits in D_W bits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[N_W-1]};
    sub_ok    = (rem_shift >= {1'b0, dsr_q});
    rem_d     = sub_ok ? (rem_shift[D_W-1:0] - dsr_q) : rem_shift[D_W-1:0];
    quo_d     = {quo_q[Q_W-2:0], sub_ok};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= D_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= D_IDLE;
    end else begin
      case (state_q)
        D_IDLE: begin
          if (start) begin
            quo_q <= '0;
            if (divisor == '0) begin
              state_q <= D_DONE;
            end else begin
              dvd_q   <= dividend;
              dsr_q   <= divisor;
              rem_q   <= '0;
              cnt_q   <= '0;
              state_q <= D_RUN;
            end
          end
        end
        D_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[N_W-2:0], 1'b0};
          cnt_q <= cnt_q + C_W'(1);
          if (cnt_q == C_W'(N_W - 1)) begin
            state_q <= D_DONE;
          end
        end
        D_DONE:  state_q <= D_IDLE;
        default: state_q <= D_IDLE;
      endcase
    end
  end

  assign quotient = quo_q;
  assign busy     = (state_q != D_IDLE);
  assign done     = (state_q == D_DONE);

endmodule

// File: rtl/react_score_keeper.sv
// rtl/react_score_keeper.sv - per-player reaction time accumulation and truncated averaging
//
// Purpose: accumulates clamped reaction times per player on STORAGE entry and
// computes the truncated mean with seq_divider on AVERAGE entry.
// Ports:
//   clk, rstn          : clock, async active-low reset
//   machine_state      : top FSM state code (react_score_keeper_pkg encoding)
//   cur_player         : 1 = player A, 0 = player B
//   react_time         : measured reaction time in ms, clamped to TIME_MAX
//   clr_scores         : sync clear of sums, counts, averages; aborts the divider
//   avr_react_time_A/B : truncated mean per player, held between updates
//   trials_A/B         : stored trial count per player
//   avr_busy           : divider running
//   avr_done           : one-cycle pulse when an average is written
//   store_full         : current player's trial count equals MAX_TRIALS
module react_score_keeper
  import react_score_keeper_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        machine_state,
  input  logic              cur_player,
  input  logic [TIME_W-1:0] react_time,
  input  logic              clr_scores,
  output logic [TIME_W-1:0] avr_react_time_A,
  output logic [TIME_W-1:0] avr_react_time_B,
  output logic [CNT_W-1:0]  trials_A,
  output logic [CNT_W-1:0]  trials_B,
  output logic              avr_busy,
  output logic              avr_done,
  output logic              store_full
);

  logic [2:0]        prev_state_q;
  logic [SUM_W-1:0]  sum_q [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [TIME_W-1:0] avr_q [2];
  logic              tgt_q;
  logic              avr_done_q;

  logic              store_entry;
  logic              avr_entry;
  logic              can_store;
  logic [SUM_W-1:0]  sum_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [TIME_W-1:0] div_quotient;

  // Events fire once, on the first cycle a state is presented.
  assign store_entry = (machine_state == STORAGE) && (prev_state_q != STORAGE);
  assign avr_entry   = (machine_state == AVERAGE) && (prev_state_q != AVERAGE);

  assign can_store = (cnt_q[cur_player] < CNT_W'(MAX_TRIALS));
  assign sum_d     = sum_q[cur_player] + SUM_W'(clamp_time(react_time, TIME_W'(TIME_MAX)));
  assign cnt_d     = cnt_q[cur_player] + CNT_W'(1);

  // A re-entry while the divider is occupied is dropped; the snapshot taken
  // here is all the divider sees, so later stores do not disturb it.
  assign div_start = avr_entry && !div_busy;

  seq_divider #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (TIME_W)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .abort    (clr_scores),
    .dividend (sum_q[cur_player]),
    .divisor  (cnt_q[cur_player]),
    .quotient (div_quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_state_q <= IDLE;
      sum_q[0]     <= '0;
      sum_q[1]     <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      avr_q[0]     <= '0;
      avr_q[1]     <= '0;
      tgt_q        <= 1'b0;
      avr_done_q   <= 1'b0;
    end else begin
      prev_state_q <= machine_state;
      avr_done_q   <= 1'b0;
      if (clr_scores) begin
        sum_q[0] <= '0;
        sum_q[1] <= '0;
        cnt_q[0] <= '0;
        cnt_q[1] <= '0;
        avr_q[0] <= '0;
        avr_q[1] <= '0;
      end else begin
        if (store_entry && can_store) begin
          sum_q[cur_player] <= sum_d;
          cnt_q[cur_player] <= cnt_d;
        end
        if (div_start) begin
          tgt_q <= cur_player;
        end
        if (div_done) begin
          avr_q[tgt_q] <= div_quotient;
          avr_done_q   <= 1'b1;
        end
      end
    end
  end

  assign avr_react_time_A = avr_q[PLAYER_A];
  assign avr_react_time_B = avr_q[PLAYER_B];
  assign trials_A         = cnt_q[PLAYER_A];
  assign trials_B         = cnt_q[PLAYER_B];
  assign avr_busy         = div_busy;
  assign avr_done         = avr_done_q;
  assign store_full       = (cnt_q[cur_player] == CNT_W'(MAX_TRIALS));

endmodule
